// File: rtl/fp_ftoi.sv
// Two-stage binary32 -> signed int32 converter with per-op rounding mode,
// saturation on overflow/NaN/Inf, and invalid/inexact flags.
module fp_ftoi #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] float_in,
    input  logic [1:0]            round_mode,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] int_result,
    output logic                  flag_invalid,
    output logic                  flag_inexact
);

    localparam int EXP_WIDTH  = 8;
    localparam int MANT_WIDTH = 23;
    localparam int BIAS       = 127;

    localparam logic [1:0] RM_RNE = 2'b00;
    localparam logic [1:0] RM_RTZ = 2'b01;
    localparam logic [1:0] RM_RDN = 2'b10;
    localparam logic [1:0] RM_RUP = 2'b11;

    localparam logic [EXP_WIDTH-1:0] EXP_MAX   = '1;
    localparam logic [EXP_WIDTH-1:0] EXP_BIAS  = EXP_WIDTH'(BIAS);
    localparam logic [EXP_WIDTH-1:0] EXP_OVF   = EXP_WIDTH'(BIAS + 31);
    localparam logic [EXP_WIDTH-1:0] EXP_HALF  = EXP_WIDTH'(BIAS - 1);
    localparam logic [31:0]          INT_MAX   = 32'h7FFF_FFFF;
    localparam logic [31:0]          INT_MIN   = 32'h8000_0000;

    generate
        if (DATA_WIDTH != 32) begin : g_width_check
            $fatal(1, "fp_ftoi: DATA_WIDTH must be 32");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic r_s1_valid;
    logic r_out_valid;
    logic w_adv;
    logic w_accept;

    assign w_adv      = !r_out_valid || out_ready;
    assign in_ready   = !r_s1_valid || w_adv;
    assign w_accept   = in_valid && in_ready;
    assign out_valid  = r_out_valid;

    // ------------------------------------------------------------------
    // Stage 1: unpack, classify, align
    // ------------------------------------------------------------------
    logic                  w_sign;
    logic [EXP_WIDTH-1:0]  w_exp;
    logic [MANT_WIDTH-1:0] w_frac;
    logic [MANT_WIDTH:0]   w_sig;
    logic [EXP_WIDTH-1:0]  w_e_unb;
    logic [54:0]           w_shift;
    logic                  w_frac_nz;

    logic        w_nan;
    logic        w_inf;
    logic        w_ovf_pre;
    logic [31:0] w_mag;
    logic        w_guard;
    logic        w_sticky;

    assign w_sign    = float_in[31];
    assign w_exp     = float_in[30:23];
    assign w_frac    = float_in[22:0];
    assign w_sig     = {1'b1, w_frac};
    assign w_frac_nz = |w_frac;
    assign w_e_unb   = w_exp - EXP_BIAS;
    // Value = w_shift * 2^-23: top bits are the integer part, low 23 the fraction.
    assign w_shift   = {31'b0, w_sig} << w_e_unb;

    always_comb begin
        w_nan     = 1'b0;
        w_inf     = 1'b0;
        w_ovf_pre = 1'b0;
        w_mag     = '0;
        w_guard   = 1'b0;
        w_sticky  = 1'b0;
        if (w_exp == EXP_MAX) begin
            w_nan = w_frac_nz;
            w_inf = !w_frac_nz;
        end else if (w_exp == '0) begin
            // Zero is exact; any denormal is a tiny nonzero fraction.
            w_sticky = w_frac_nz;
        end else if (w_exp >= EXP_OVF) begin
            if (w_sign && (w_exp == EXP_OVF) && !w_frac_nz) begin
                w_mag = INT_MIN;
            end else begin
                w_ovf_pre = 1'b1;
            end
        end else if (w_exp >= EXP_BIAS) begin
            w_mag    = w_shift[54:23];
            w_guard  = w_shift[22];
            w_sticky = |w_shift[21:0];
        end else if (w_exp == EXP_HALF) begin
            w_guard  = 1'b1;
            w_sticky = w_frac_nz;
        end else begin
            w_sticky = 1'b1;
        end
    end

    logic        r_s1_sign;
    logic [1:0]  r_s1_mode;
    logic        r_s1_nan;
    logic        r_s1_inf;
    logic        r_s1_ovf_pre;
    logic [31:0] r_s1_mag;
    logic        r_s1_guard;
    logic        r_s1_sticky;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid   <= 1'b0;
            r_s1_sign    <= 1'b0;
            r_s1_mode    <= '0;
            r_s1_nan     <= 1'b0;
            r_s1_inf     <= 1'b0;
            r_s1_ovf_pre <= 1'b0;
            r_s1_mag     <= '0;
            r_s1_guard   <= 1'b0;
            r_s1_sticky  <= 1'b0;
        end else if (in_ready) begin
            r_s1_valid <= in_valid;
            if (w_accept) begin
                r_s1_sign    <= w_sign;
                r_s1_mode    <= round_mode;
                r_s1_nan     <= w_nan;
                r_s1_inf     <= w_inf;
                r_s1_ovf_pre <= w_ovf_pre;
                r_s1_mag     <= w_mag;
                r_s1_guard   <= w_guard;
                r_s1_sticky  <= w_sticky;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: round, range check, pack
    // ------------------------------------------------------------------
    logic        w_inc;
    logic        w_lost;
    logic [32:0] w_mag_r;
    logic        w_ovf;
    logic        w_invalid;
    logic [31:0] w_result;

    assign w_lost = r_s1_guard || r_s1_sticky;

    always_comb begin
        w_inc = 1'b0;
        case (r_s1_mode)
            RM_RNE:  w_inc = r_s1_guard && (r_s1_sticky || r_s1_mag[0]);
            RM_RTZ:  w_inc = 1'b0;
            RM_RDN:  w_inc = r_s1_sign && w_lost;
            RM_RUP:  w_inc = !r_s1_sign && w_lost;
            default: w_inc = 1'b0;
        endcase
    end

    assign w_mag_r   = {1'b0, r_s1_mag} + {32'b0, w_inc};
    assign w_ovf     = r_s1_ovf_pre
                     || (!r_s1_sign && (w_mag_r > {1'b0, INT_MAX}))
                     || ( r_s1_sign && (w_mag_r > {1'b0, INT_MIN}));
    assign w_invalid = r_s1_nan || r_s1_inf || w_ovf;

    always_comb begin
        w_result = '0;
        if (r_s1_nan) begin
            w_result = INT_MAX;
        end else if (r_s1_inf || w_ovf) begin
            w_result = r_s1_sign ? INT_MIN : INT_MAX;
        end else if (r_s1_sign) begin
            w_result = (~w_mag_r[31:0]) + 32'd1;
        end else begin
            w_result = w_mag_r[31:0];
        end
    end

    logic [31:0] r_int_result;
    logic        r_flag_invalid;
    logic        r_flag_inexact;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_int_result   <= '0;
            r_flag_invalid <= 1'b0;
            r_flag_inexact <= 1'b0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_int_result   <= w_result;
                r_flag_invalid <= w_invalid;
                r_flag_inexact <= w_lost && !w_invalid;
            end
        end
    end

    assign int_result   = r_int_result;
    assign flag_invalid = r_flag_invalid;
    assign flag_inexact = r_flag_inexact;

endmodule
